hilo_muldiv_unit: RTL

//  Execution-side consumer of the decoder's multordiv/hlwrite/mvhl controls.

---
 rtl/hilo_muldiv_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative signed MULT/DIV engine owning the HI/LO pair.
// One multiplier or quotient bit is resolved per cycle on operand magnitudes.
// The sign correction is applied in a final FIX cycle, and the read port
// serves MFHI/MFLO. While a result is pending, stall holds the pipeline
// against reads of HI/LO and against a new start request.
//
// state | meaning
// IDLE  | no operation in flight, HI/LO stable, start requests accepted
// MUL   | shift-add, one multiplier bit per cycle for WIDTH cycles
// DIV   | restoring shift-subtract, one quotient bit per cycle for WIDTH cycles
// FIX   | apply result signs, write HI/LO at the end of the cycle
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hlwrite,
    input  logic             multordiv,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       mvhl,
    output logic [WIDTH-1:0] hlout,
    output logic             busy,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   op_a, mag_b;
    logic               op_mul, neg_res, neg_rem, div_zero;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    logic [WIDTH-1:0]   mag_srca, mag_srcb;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // still correct when the bits are read as unsigned.
    always_comb begin
        mag_srca  = srca[WIDTH-1] ? -srca : srca;
        mag_srcb  = srcb[WIDTH-1] ? -srcb : srcb;
        last_iter = (count == CW'(WIDTH - 1));
        // Upper half plus multiplicand, keeping the carry for the right shift.
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_b} : '0);
        // Partial remainder carries one extra bit so the borrow is visible.
        rem_shift = {rem, quo[WIDTH-1]};
        div_diff  = rem_shift - {1'b0, mag_b};
        div_ok    = ~div_diff[WIDTH];
        prod_fix  = neg_res ? -prod : prod;
        quo_fix   = neg_res ? -quo : quo;
        rem_fix   = neg_rem ? -rem : rem;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; a zero divisor skips the iterations entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hlwrite) begin
                if (multordiv)         state_nxt = MUL;
                else if (srcb == '0)   state_nxt = FIX;
                else                   state_nxt = DIV;
            end
            MUL:  if (last_iter) state_nxt = FIX;
            DIV:  if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: busy/stall from state, read mux from the registered HI/LO.
    always_comb begin
        busy  = (state != IDLE);
        stall = busy & ((mvhl == 2'b01) | (mvhl == 2'b10) | hlwrite);
        case (mvhl)
            2'b01:   hlout = lo;
            2'b10:   hlout = hi;
            default: hlout = '0;
        endcase
    end

    // Datapath: operand capture, iteration steps and the final HI/LO write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            op_a     <= '0;
            mag_b    <= '0;
            op_mul   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: if (hlwrite) begin
                    count    <= '0;
                    op_a     <= srca;
                    mag_b    <= mag_srcb;
                    op_mul   <= multordiv;
                    neg_res  <= srca[WIDTH-1] ^ srcb[WIDTH-1];
                    neg_rem  <= srca[WIDTH-1];
                    div_zero <= (srcb == '0);
                    prod     <= {{WIDTH{1'b0}}, mag_srca};
                    quo      <= mag_srca;
                    rem      <= '0;
                end
                MUL: begin
                    prod  <= {mul_sum, prod[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                DIV: begin
                    rem   <= div_ok ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], div_ok};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (op_mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= op_a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
